// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int SPI_ARB_DATA_W = 8;
  localparam int SPI_ARB_DIV_W  = 3;

  // Requester index found 'off' slots past 'ptr', wrapping at n.
  function automatic logic [2:0] rr_index(input logic [2:0] ptr, input int unsigned off,
                                          input int unsigned n);
    int unsigned sum;
    sum = 32'(ptr) + off;
    if (sum >= n) sum = sum - n;
    return sum[2:0];
  endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Combinational round-robin picker: first set request at or after rr_ptr wins.
module spi_arb_rr
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic               valid,
  output logic [2:0]         winner
);

  logic [7:0] w_req_ext;

  assign w_req_ext = 8'(req);

  // Walk from the farthest slot back to rr_ptr so the closest hit is assigned last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_ext[rr_index(rr_ptr, i, NUM_REQ)]) begin
        valid  = 1'b1;
        winner = rr_index(rr_ptr, i, NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = SPI_ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*DATA_W-1:0]        req_data,
  input  logic [NUM_REQ*SPI_ARB_DIV_W-1:0] req_div,
  output logic [NUM_REQ-1:0]               ack,
  output logic [NUM_REQ-1:0]               err,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             busy,
  output logic [2:0]                       gnt_id,
  output logic                             m_start,
  output logic                             m_write_enable,
  output logic [DATA_W-1:0]                m_data,
  output logic [SPI_ARB_DIV_W-1:0]         m_clock_div,
  input  logic                             m_done,
  input  logic [DATA_W-1:0]                m_rdata
);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic [2:0]                r_rr_ptr;
  logic [2:0]                r_gnt_id;
  logic [NUM_REQ-1:0]        r_ack;
  logic [DATA_W-1:0]         r_rsp_data;
  logic                      r_busy;
  logic                      r_m_start;
  logic                      r_m_wr;
  logic [DATA_W-1:0]         r_m_data;
  logic [SPI_ARB_DIV_W-1:0]  r_m_div;

  logic                      w_valid;
  logic [2:0]                w_winner;
  logic                      w_sel_wr;
  logic [DATA_W-1:0]         w_sel_data;
  logic [SPI_ARB_DIV_W-1:0]  w_sel_div;
  logic [NUM_REQ-1:0]        w_gnt_oh;
  logic                      w_timeout;

  spi_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_valid),
    .winner (w_winner)
  );

  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_data = '0;
    w_sel_div  = '0;
    w_gnt_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_wr   = req_wr[i];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
        w_sel_div  = req_div[i*SPI_ARB_DIV_W +: SPI_ARB_DIV_W];
      end
      w_gnt_oh[i] = (r_gnt_id == 3'(i));
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]   r_to_cnt;
  logic [NUM_REQ-1:0] r_err;

  // Loaded while leaving START, so it reaches zero after TIMEOUT_CYCLES full WAIT cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
      r_err    <= '0;
    end else begin
      if (r_state == ST_START)
        r_to_cnt <= CNT_W'(TIMEOUT_CYCLES);
      else if (r_state == ST_WAIT && r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - CNT_W'(1);
      r_err <= w_timeout ? w_gnt_oh : '0;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !m_done && (r_to_cnt == '0);
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_valid) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (m_done || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_ack      <= '0;
      r_rsp_data <= '0;
      r_busy     <= 1'b0;
      r_m_start  <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_data   <= '0;
      r_m_div    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_m_start <= (w_state_nxt == ST_START);
      r_ack     <= (w_state_nxt == ST_RESP) ? w_gnt_oh : '0;
      if (r_state == ST_IDLE && w_valid) begin
        r_gnt_id <= w_winner;
        r_m_wr   <= w_sel_wr;
        r_m_data <= w_sel_data;
        r_m_div  <= w_sel_div;
      end
      if (r_state == ST_WAIT) begin
        if (m_done)
          r_rsp_data <= m_rdata;
        else if (w_timeout)
          r_rsp_data <= '0;
      end
      if (r_state == ST_RESP)
        r_rr_ptr <= (r_gnt_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_gnt_id + 3'd1;
    end
  end

  assign ack            = r_ack;
  assign rsp_data       = r_rsp_data;
  assign busy           = r_busy;
  assign gnt_id         = r_gnt_id;
  assign m_start        = r_m_start;
  assign m_write_enable = r_m_wr;
  assign m_data         = r_m_data;
  assign m_clock_div    = r_m_div;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed plus randomized bench for spi_arbiter with a behavioural SPI master/slave stand-in.
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr;
  logic [N*DW-1:0] req_data;
  logic [N*3-1:0]  req_div;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [2:0]      gnt_id;
  logic            m_start;
  logic            m_write_enable;
  logic [DW-1:0]   m_data;
  logic [2:0]      m_clock_div;
  logic            m_done;
  logic [DW-1:0]   m_rdata;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;

  always #5 clock = ~clock;

  spi_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .req_wr         (req_wr),
    .req_data       (req_data),
    .req_div        (req_div),
    .ack            (ack),
    .err            (err),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .gnt_id         (gnt_id),
    .m_start        (m_start),
    .m_write_enable (m_write_enable),
    .m_data         (m_data),
    .m_clock_div    (m_clock_div),
    .m_done         (m_done),
    .m_rdata        (m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = 8'($urandom);
      req_div[i*3 +: 3]    = 3'($urandom);
      req_wr[i]            = 1'($urandom);
    end
  endtask

  // One full transaction, entered on a negedge with the DUT idle (or about to be).
  task automatic serve(input int lat, input logic [DW-1:0] sw, input bit keep, input bit spur,
                       input logic [N-1:0] add, input bit drop);
    int            w;
    int            n;
    logic [DW-1:0] ed;
    logic          ewr;
    logic [2:0]    ediv;
    logic [N-1:0]  eack;
    w = pick(req, ptr_m);
    if (w < 0) w = 0;
    ed   = req_data[w*DW +: DW];
    ewr  = req_wr[w];
    ediv = req_div[w*3 +: 3];
    eack = '0;
    eack[w] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_start && n < 8);
    chk("start_latency", 32'(n), 32'd1);
    if (!m_start) return;
    chk("gnt_id", 32'(gnt_id), 32'(w));
    chk("m_data", 32'(m_data), 32'(ed));
    chk("m_write_enable", 32'(m_write_enable), 32'(ewr));
    chk("m_clock_div", 32'(m_clock_div), 32'(ediv));
    chk("busy_start", 32'(busy), 32'd1);
    if (spur) m_done = 1'b1;
    @(negedge clock);
    m_done = 1'b0;
    chk("start_one_cycle", 32'(m_start), 32'd0);
    if (add != '0) begin
      req = req | add;
      randomize_operands();
    end
    if (drop) req[w] = 1'b0;
    for (int c = 0; c < lat; c++) begin
      chk("wait_hold_data", 32'(m_data), 32'(ed));
      chk("wait_no_ack", 32'(ack), 32'd0);
      @(negedge clock);
    end
    chk("pre_done_no_ack", 32'(ack), 32'd0);
    m_done  = 1'b1;
    m_rdata = sw;
    @(negedge clock);
    m_done  = 1'b0;
    m_rdata = 8'($urandom);
    chk("ack_onehot", 32'(ack), 32'(eack));
    chk("err_clear", 32'(err), 32'd0);
    chk("rsp_data", 32'(rsp_data), 32'(sw));
    chk("gnt_at_ack", 32'(gnt_id), 32'(w));
    chk("m_data_at_ack", 32'(m_data), 32'(ed));
    req[w] = keep;
    if (spur) m_done = 1'b1;
    ptr_m = (w + 1) % N;
    @(negedge clock);
    m_done = 1'b0;
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rsp_hold", 32'(rsp_data), 32'(sw));
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    req      = '0;
    req_wr   = '0;
    req_data = '0;
    req_div  = '0;
    m_done   = 1'b0;
    m_rdata  = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_div", 32'(m_clock_div), 32'd0);
    chk("rst_m_wr", 32'(m_write_enable), 32'd0);
    chk("rst_rsp", 32'(rsp_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Contention: all four held, expect 0,1,2,3,0.
    randomize_operands();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      chk("contention_order", 32'(pick(req, ptr_m)), 32'(k % N));
      serve(1, 8'($urandom), 1'b1, 1'b0, '0, 1'b0);
    end
    req = '0;

    // Single request to requester 0 with the slave seeing 8'hAA.
    req_data[0 +: DW] = 8'hAA;
    req_wr[0]         = 1'b0;
    req_div[0 +: 3]   = 3'd2;
    req[0]            = 1'b1;
    serve(3, 8'h5A, 1'b0, 1'b0, '0, 1'b0);

    // m_done while idle must not start anything.
    m_done = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("idle_done_busy", 32'(busy), 32'd0);
      chk("idle_done_ack", 32'(ack), 32'd0);
    end
    m_done = 1'b0;

    // Read-back from requester 2.
    req_wr[2]          = 1'b1;
    req_data[2*DW +: DW] = 8'h33;
    req_div[2*3 +: 3]  = 3'd5;
    req[2]             = 1'b1;
    serve(2, 8'h6D, 1'b0, 1'b1, '0, 1'b0);

    // Late arrival of requester 1 during requester 3's WAIT.
    req = 4'b1000;
    serve(4, 8'hC3, 1'b0, 1'b0, 4'b0010, 1'b0);
    chk("late_next_pick", 32'(pick(req, ptr_m)), 32'd1);
    serve(1, 8'h11, 1'b1, 1'b0, '0, 1'b0);
    serve(0, 8'h22, 1'b0, 1'b0, '0, 1'b0);

    // Reset in WAIT of requester 2 (pointer sits at 2).
    req = 4'b0100;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_start && n < 8);
    chk("rst_test_start", 32'(m_start), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_m_start", 32'(m_start), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    @(negedge clock);
    chk("abort_ack2", 32'(ack), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ptr_m   = 0;
    req     = 4'b1010;
    chk("post_rst_pick", 32'(pick(req, ptr_m)), 32'd1);
    serve(1, 8'h99, 1'b0, 1'b0, '0, 1'b0);
    req = '0;

    // Randomized traffic against the reference arbitration.
    for (int it = 0; it < 40; it++) begin
      req = req | 4'($urandom);
      if (req == '0) req[$urandom_range(0, N-1)] = 1'b1;
      randomize_operands();
      serve($urandom_range(0, 4), 8'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), ($urandom_range(0, 3) == 0));
    end
    req = '0;
    @(negedge clock);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: m_done never arrives.
    req = '0;
    req[ptr_m] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_start && n < 8);
    chk("to_start", 32'(m_start), 32'd1);
    @(negedge clock);
    n = 1;
    while (ack == '0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("to_cycles", 32'(n - 1), 32'd17);
    chk("to_ack", 32'(ack), 32'd1 << ptr_m);
    chk("to_err", 32'(err), 32'd1 << ptr_m);
    chk("to_rsp", 32'(rsp_data), 32'd0);
    req = '0;
    ptr_m = (ptr_m + 1) % N;
    @(negedge clock);
    chk("to_err_pulse", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
